lsu: RTL and testbench
======================

Name: lsu

Overview:
- Load/store unit of the MEM stage, directly downstream of the EX/MEM pipeline register.
- Consumes the registered EX results (uop, memory address, store data, rd/CSR write info, exception word, pc, instruction).
- Performs the data-bus transaction with a req/gnt/rvalid handshake, then aligns and extends load data.
- Forwards the write-back bundle to MEM/WB and raises stall_req_o to ctrl while a transaction is outstanding.

Parameters:
EXC_LD_MIS, 4, exception_o bit set on misaligned load
EXC_LD_ERR, 5, exception_o bit set on load bus error
EXC_ST_MIS, 6, exception_o bit set on misaligned store
EXC_ST_ERR, 7, exception_o bit set on store bus error

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
flush_i  in  1  pipeline flush from ctrl
rd_we_i / rd_wa_i / rd_wd_i  in  1/5/32  rd write info from EX/MEM
uop_i  in  8 (`AluOpBus)  micro-op
mem_a_i / mem_wd_i  in  32/32  byte address / store data
csr_we_i / csr_wa_i / csr_wd_i  in  1/32/32  CSR write info
exception_i / pc_i / ins_i  in  32/32/32  exception word, pc, instruction
dbus_req_o / dbus_we_o  out  1/1  bus request / write
dbus_be_o  out  4  byte enables
dbus_addr_o / dbus_wdata_o  out  32/32  word-aligned address / write data
dbus_gnt_i / dbus_rvalid_i / dbus_err_i  in  1/1/1  grant / response valid / response error
dbus_rdata_i  in  32  read data
rd_we_o / rd_wa_o / rd_wd_o  out  1/5/32  to MEM/WB
csr_we_o / csr_wa_o / csr_wd_o  out  1/32/32  to MEM/WB (pass-through)
exception_o / pc_o / ins_o  out  32/32/32  to MEM/WB
stall_req_o  out  1  hold pipeline stages 0..4

Behaviour:
- Interface: one clock clk_i. Reset rst_i is synchronous and active-high.
- Memory uops: UOP_LB, LH, LW, LBU, LHU, SB, SH, SW. All other uops pass through combinationally with stall_req_o=0 and no bus activity.
- FSM states: IDLE, REQ, WAIT_R, RESP. Reset → IDLE.
  - At reset: dbus_req_o=0; internal captured data and kill flag cleared.
  - Outputs are combinational from inputs/state, so in IDLE after reset they mirror the EX/MEM reset bubble (rd_we_o=0, exception_o=0, pc_o=0, ins_o=NOP_INS).
- IDLE, memory uop, aligned, exception_i==0, flush_i==0:
  - Assert dbus_req_o and stall_req_o.
  - dbus_gnt_i=1 → WAIT_R; else → REQ.
- REQ: hold req, addr, we, be and wdata stable (registered copies) until gnt, then → WAIT_R. stall_req_o=1.
- WAIT_R:
  - dbus_req_o=0, stall_req_o=1.
  - On dbus_rvalid_i: capture dbus_rdata_i and dbus_err_i → RESP.
  - rvalid arrives no earlier than the cycle after gnt.
- RESP:
  - stall_req_o=0 and outputs present the completed result, so the pipeline advances exactly once.
  - Always → IDLE; no re-issue of the same instruction.
- Minimum load/store occupancy: 3 cycles (gnt in the IDLE cycle, rvalid next cycle), of which 2 are stalled.
- Address and write data:
  - dbus_addr_o = {mem_a[31:2], 2'b00}.
  - SB: be = 4'b0001 << a[1:0]; wdata = {4{wd[7:0]}}.
  - SH: be = 4'b0011 << {a[1],1'b0}; wdata = {2{wd[15:0]}}.
  - SW: be = 4'b1111; wdata = wd.
  - Loads: dbus_we_o=0, be=4'b1111.
- Load data:
  - Shift captured rdata right by 8*a[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW unchanged.
  - Result drives rd_wd_o in RESP. Non-load uops: rd_wd_o = rd_wd_i.
- Misaligned access (LH/LHU/SH with a[0]=1; LW/SW with a[1:0]≠0):
  - No bus access and no stall.
  - exception_o = exception_i | (1<<EXC_*_MIS); rd_we_o=0.
- exception_i≠0 on a memory uop: no bus access; all inputs pass through unchanged.
- dbus_err_i captured at RESP: exception_o |= 1<<EXC_LD_ERR or EXC_ST_ERR; rd_we_o=0.
- CSR, pc and ins fields always pass through unchanged.
- flush_i:
  - In IDLE: no request is issued.
  - In REQ or WAIT_R: the bus transaction runs to completion (no request retraction). A kill flag is set, and RESP then drives a bubble: rd_we_o=0, csr_we_o=0, exception_o=0, ins_o=NOP_INS.
- Reset mid-transaction: immediate return to IDLE with req dropped. The bus is reset in the same cycle.

Test Plan:
- LW at a=0x100, gnt same cycle, rvalid next cycle with rdata 0xDEADBEEF → stall_req_o high 2 cycles; RESP shows rd_wd_o=0xDEADBEEF, rd_we_o=1.
- LB at a=0x103, rdata 0x80FF_1234 → rd_wd_o=0xFFFFFF80. Same access with LBU → rd_wd_o=0x00000080.
- SH at a=0x202, wd=0x0000ABCD, gnt delayed 3 cycles → be=4'b1100, wdata=0xABCDABCD, addr=0x200; all held stable until gnt.
- LW at a=0x101 → no dbus_req_o, stall_req_o=0, exception_o bit 4 set, rd_we_o=0.
- SW with dbus_err_i=1 at rvalid → exception_o bit 7 set in RESP.
- flush_i asserted during WAIT_R → transaction completes; RESP outputs bubble with rd_we_o=0.

Source files
------------

// File: rtl/lsu_if.sv
// Data-bus interface between the load/store unit and memory.
// Request phase: req/we/be/addr/wdata held until gnt; response phase: rvalid/err/rdata.
// The master holds a request stable until it is granted; the slave answers later with one rvalid.
interface lsu_if;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic        err;
  logic [31:0] rdata;

  modport master (output req, we, be, addr, wdata, input gnt, rvalid, err, rdata);
  modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, err, rdata);
endinterface

// File: rtl/lsu.sv
// MEM-stage load/store unit: issues one data-bus access per memory uop and aligns/extends load data.
// Latency: non-memory uops and rejected accesses pass through combinationally; an access takes >= 3 cycles.
// Backpressure: stall_req_o holds the pipeline from issue until the response; a stalled bus request stays stable.
module lsu #(
  parameter int          EXC_LD_MIS = 4,
  parameter int          EXC_LD_ERR = 5,
  parameter int          EXC_ST_MIS = 6,
  parameter int          EXC_ST_ERR = 7,
  parameter logic [7:0]  UOP_LB     = 8'h20,
  parameter logic [7:0]  UOP_LH     = 8'h21,
  parameter logic [7:0]  UOP_LW     = 8'h22,
  parameter logic [7:0]  UOP_LBU    = 8'h23,
  parameter logic [7:0]  UOP_LHU    = 8'h24,
  parameter logic [7:0]  UOP_SB     = 8'h25,
  parameter logic [7:0]  UOP_SH     = 8'h26,
  parameter logic [7:0]  UOP_SW     = 8'h27,
  parameter logic [31:0] NOP_INS    = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        rd_we_i,
  input  logic [4:0]  rd_wa_i,
  input  logic [31:0] rd_wd_i,
  input  logic [7:0]  uop_i,
  input  logic [31:0] mem_a_i,
  input  logic [31:0] mem_wd_i,
  input  logic        csr_we_i,
  input  logic [31:0] csr_wa_i,
  input  logic [31:0] csr_wd_i,
  input  logic [31:0] exception_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] ins_i,
  lsu_if.master       dbus,
  output logic        rd_we_o,
  output logic [4:0]  rd_wa_o,
  output logic [31:0] rd_wd_o,
  output logic        csr_we_o,
  output logic [31:0] csr_wa_o,
  output logic [31:0] csr_wd_o,
  output logic [31:0] exception_o,
  output logic [31:0] pc_o,
  output logic [31:0] ins_o,
  output logic        stall_req_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, RESP} state_t;

  state_t      state_q, state_d;
  logic        kill_q, kill_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        is_load, is_store, is_mem, misaligned, start;
  logic [3:0]  be_c;
  logic [31:0] wdata_c, ld_sh, ld_val;

  // Decode the current uop: access type, alignment, byte lanes and replicated store data.
  always_comb begin
    is_load    = (uop_i == UOP_LB) || (uop_i == UOP_LH) || (uop_i == UOP_LW) ||
                 (uop_i == UOP_LBU) || (uop_i == UOP_LHU);
    is_store   = (uop_i == UOP_SB) || (uop_i == UOP_SH) || (uop_i == UOP_SW);
    is_mem     = is_load || is_store;
    misaligned = (((uop_i == UOP_LH) || (uop_i == UOP_LHU) || (uop_i == UOP_SH)) && mem_a_i[0]) ||
                 (((uop_i == UOP_LW) || (uop_i == UOP_SW)) && (mem_a_i[1:0] != 2'b00));
    be_c       = 4'b1111;
    wdata_c    = mem_wd_i;
    if (uop_i == UOP_SB) begin
      be_c    = 4'b0001 << mem_a_i[1:0];
      wdata_c = {4{mem_wd_i[7:0]}};
    end else if (uop_i == UOP_SH) begin
      be_c    = 4'b0011 << {mem_a_i[1], 1'b0};
      wdata_c = {2{mem_wd_i[15:0]}};
    end
    // Reset wins over a fresh issue so the bus never sees a request while in reset.
    start = (state_q == IDLE) && is_mem && !misaligned && (exception_i == '0) && !flush_i && !rst_i;
  end

  // Shift the captured response word down to the addressed byte and extend it.
  always_comb begin
    ld_sh  = rdata_q >> {mem_a_i[1:0], 3'b000};
    ld_val = ld_sh;
    case (uop_i)
      UOP_LB:  ld_val = {{24{ld_sh[7]}}, ld_sh[7:0]};
      UOP_LH:  ld_val = {{16{ld_sh[15]}}, ld_sh[15:0]};
      UOP_LBU: ld_val = {24'd0, ld_sh[7:0]};
      UOP_LHU: ld_val = {16'd0, ld_sh[15:0]};
      default: ld_val = ld_sh;
    endcase
  end

  // Transaction FSM next state, captured request/response and bus drive.
  always_comb begin
    state_d     = state_q;
    kill_d      = kill_q;
    we_d        = we_q;
    be_d        = be_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    dbus.req    = 1'b0;
    dbus.we     = we_q;
    dbus.be     = be_q;
    dbus.addr   = addr_q;
    dbus.wdata  = wdata_q;
    stall_req_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          dbus.req    = 1'b1;
          dbus.we     = is_store;
          dbus.be     = be_c;
          dbus.addr   = {mem_a_i[31:2], 2'b00};
          dbus.wdata  = wdata_c;
          stall_req_o = 1'b1;
          we_d        = is_store;
          be_d        = be_c;
          addr_d      = {mem_a_i[31:2], 2'b00};
          wdata_d     = wdata_c;
          kill_d      = 1'b0;
          state_d     = dbus.gnt ? WAIT_R : REQ;
        end
      end
      REQ: begin
        dbus.req    = 1'b1;
        stall_req_o = 1'b1;
        if (flush_i) kill_d = 1'b1;
        if (dbus.gnt) state_d = WAIT_R;
      end
      WAIT_R: begin
        stall_req_o = 1'b1;
        if (flush_i) kill_d = 1'b1;
        if (dbus.rvalid) begin
          rdata_d = dbus.rdata;
          err_d   = dbus.err;
          state_d = RESP;
        end
      end
      RESP: begin
        kill_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst_i) begin
      dbus.req    = 1'b0;
      stall_req_o = 1'b0;
    end
  end

  // Write-back bundle: pass-through unless rejected as misaligned or completing an access.
  always_comb begin
    rd_we_o     = rd_we_i;
    rd_wa_o     = rd_wa_i;
    rd_wd_o     = rd_wd_i;
    csr_we_o    = csr_we_i;
    csr_wa_o    = csr_wa_i;
    csr_wd_o    = csr_wd_i;
    exception_o = exception_i;
    pc_o        = pc_i;
    ins_o       = ins_i;
    if ((state_q == IDLE) && is_mem && misaligned && (exception_i == '0)) begin
      exception_o = exception_i | (32'd1 << (is_load ? EXC_LD_MIS : EXC_ST_MIS));
      rd_we_o     = 1'b0;
    end else if (state_q == RESP) begin
      if (kill_q) begin
        rd_we_o     = 1'b0;
        csr_we_o    = 1'b0;
        exception_o = '0;
        ins_o       = NOP_INS;
      end else begin
        if (is_load) rd_wd_o = ld_val;
        if (err_q) begin
          exception_o = exception_i | (32'd1 << (is_load ? EXC_LD_ERR : EXC_ST_ERR));
          rd_we_o     = 1'b0;
        end
      end
    end
  end

  // State and capture registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      kill_q  <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: random memory/non-memory uops against a spec-level reference model.
// A bus responder with planned gnt/rvalid delays checks requests; a monitor checks write-back.
// Expected results are queued at issue time and popped whenever the pipeline advances.
module tb_lsu;
  localparam logic [7:0]  LB = 8'h20, LH = 8'h21, LW = 8'h22, LBU = 8'h23, LHU = 8'h24;
  localparam logic [7:0]  SB = 8'h25, SH = 8'h26, SW = 8'h27;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_i, flush_i, rd_we_i, csr_we_i;
  logic [4:0]  rd_wa_i;
  logic [7:0]  uop_i;
  logic [31:0] rd_wd_i, mem_a_i, mem_wd_i, csr_wa_i, csr_wd_i, exception_i, pc_i, ins_i;
  logic        rd_we_o, csr_we_o, stall_req_o;
  logic [4:0]  rd_wa_o;
  logic [31:0] rd_wd_o, csr_wa_o, csr_wd_o, exception_o, pc_o, ins_o;

  lsu_if dbus();

  always #5 clk = ~clk;

  lsu #(.UOP_LB(LB), .UOP_LH(LH), .UOP_LW(LW), .UOP_LBU(LBU), .UOP_LHU(LHU),
        .UOP_SB(SB), .UOP_SH(SH), .UOP_SW(SW), .NOP_INS(NOP)) u_dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .rd_we_i(rd_we_i), .rd_wa_i(rd_wa_i), .rd_wd_i(rd_wd_i),
    .uop_i(uop_i), .mem_a_i(mem_a_i), .mem_wd_i(mem_wd_i),
    .csr_we_i(csr_we_i), .csr_wa_i(csr_wa_i), .csr_wd_i(csr_wd_i),
    .exception_i(exception_i), .pc_i(pc_i), .ins_i(ins_i),
    .dbus(dbus),
    .rd_we_o(rd_we_o), .rd_wa_o(rd_wa_o), .rd_wd_o(rd_wd_o),
    .csr_we_o(csr_we_o), .csr_wa_o(csr_wa_o), .csr_wd_o(csr_wd_o),
    .exception_o(exception_o), .pc_o(pc_o), .ins_o(ins_o),
    .stall_req_o(stall_req_o)
  );

  typedef struct {
    logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata;
    int gdly; int rdly; logic [31:0] rdata; logic err;
  } bus_t;
  typedef struct {
    logic rd_we; logic [4:0] rd_wa; logic [31:0] rd_wd; logic chk_wd;
    logic csr_we; logic [31:0] csr_wa; logic [31:0] csr_wd;
    logic [31:0] exc; logic [31:0] pc; logic [31:0] ins;
  } wb_t;

  bus_t bus_q[$];
  wb_t  wb_q[$];
  int   n_cmp = 0, n_err = 0;
  bit   bus_en = 0, mon_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int size_of(input logic [7:0] u);
    if (u == LB || u == LBU || u == SB) return 1;
    if (u == LH || u == LHU || u == SH) return 2;
    if (u == LW || u == SW) return 4;
    return 0;
  endfunction

  function automatic bit is_ld(input logic [7:0] u);
    return (u == LB || u == LH || u == LW || u == LBU || u == LHU);
  endfunction

  // Pick the addressed bytes out of the word, then extend by type.
  function automatic logic [31:0] load_val(input logic [7:0] u, input logic [31:0] a, input logic [31:0] rd);
    int sz = size_of(u);
    logic [31:0] v = rd >> (8 * (a % 4));
    if (sz == 1) begin
      v = v & 32'hFF;
      if (u == LB && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 2) begin
      v = v & 32'hFFFF;
      if (u == LH && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  // Issue one instruction at posedge+1, wait for the pipeline to advance, check stall length.
  // fmode: 0 none, 1 flush in the issue cycle, 2 flush in the first stalled cycle.
  task automatic issue(input logic [7:0] u, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exc, input int fmode, input int gdly, input int rdly,
                       input logic [31:0] rdata, input logic err);
    int   sz = size_of(u);
    bit   mem = (sz > 0);
    bit   ld = is_ld(u);
    bit   mis, txn;
    int   cnt, exp_stall;
    wb_t  e;
    bus_t b;
    rd_we_i  = mem ? ld : 1'($urandom % 2);
    rd_wa_i  = 5'($urandom);
    rd_wd_i  = $urandom;
    csr_we_i = 1'($urandom % 2);
    csr_wa_i = $urandom;
    csr_wd_i = $urandom;
    pc_i     = $urandom;
    ins_i    = $urandom;
    uop_i    = u;
    mem_a_i  = a;
    mem_wd_i = wd;
    exception_i = exc;
    flush_i  = (fmode == 1);
    mis = mem && ((a % sz) != 0);
    txn = mem && !mis && (exc == 0) && (fmode != 1);
    e = '{rd_we_i, rd_wa_i, rd_wd_i, 1'b1, csr_we_i, csr_wa_i, csr_wd_i, exc, pc_i, ins_i};
    if (mem && !txn) begin
      if (ld) e.chk_wd = 1'b0;
      if (mis && exc == 0) begin
        e.exc   = exc | (32'd1 << (ld ? 4 : 6));
        e.rd_we = 1'b0;
      end
    end
    if (txn) begin
      b.addr = a & 32'hFFFF_FFFC;
      b.we   = !ld;
      b.be   = ld ? 4'hF : 4'(((1 << sz) - 1) << (a % 4));
      for (int i = 0; i < 4; i++) b.wdata[8*i +: 8] = wd[8*(i % sz) +: 8];
      b.gdly = gdly; b.rdly = rdly; b.rdata = rdata; b.err = err;
      bus_q.push_back(b);
      if (fmode == 2) begin
        e.rd_we = 1'b0; e.csr_we = 1'b0; e.exc = '0; e.ins = NOP; e.chk_wd = 1'b0;
      end else begin
        if (ld) e.rd_wd = load_val(u, a, rdata);
        if (err) begin
          e.exc   = 32'd1 << (ld ? 5 : 7);
          e.rd_we = 1'b0;
          e.chk_wd = 1'b0;
        end
      end
    end
    wb_q.push_back(e);
    exp_stall = txn ? 1 + gdly + rdly : 0;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (!stall_req_o) break;
      cnt++;
      if (cnt > 64) begin
        n_cmp++; n_err++;
        $display("FAIL stall_timeout: stalled %0d cycles, expected %0d", cnt, exp_stall);
        break;
      end
      @(posedge clk); #1;
      flush_i = (fmode == 2 && cnt == 1);
    end
    chk("stall_cycles", cnt, exp_stall);
    @(posedge clk); #1;
    flush_i = 1'b0;
  endtask

  // Bus responder: checks each request against the plan, grants and answers with planned delays.
  initial begin
    bus_t cur;
    int   gw = -1, rvc = 0;
    bit   busy = 0;
    dbus.gnt = 1'b0; dbus.rvalid = 1'b0; dbus.err = 1'b0; dbus.rdata = '0;
    forever begin
      @(posedge clk); #2;
      dbus.gnt = 1'b0; dbus.rvalid = 1'b0; dbus.err = 1'b0;
      if (bus_en) begin
        if (busy) begin
          chk("req_low_after_gnt", dbus.req, 0);
          rvc--;
          if (rvc == 0) begin
            dbus.rvalid = 1'b1; dbus.rdata = cur.rdata; dbus.err = cur.err; busy = 0;
          end
        end else if (dbus.req) begin
          chk("req_expected", 32'(bus_q.size() != 0), 1);
          if (bus_q.size() != 0) begin
            cur = bus_q[0];
            chk("bus_addr", dbus.addr, cur.addr);
            chk("bus_we", dbus.we, cur.we);
            chk("bus_be", dbus.be, cur.be);
            if (cur.we) chk("bus_wdata", dbus.wdata, cur.wdata);
            if (gw < 0) gw = cur.gdly;
            if (gw == 0) begin
              dbus.gnt = 1'b1;
              void'(bus_q.pop_front());
              busy = 1; rvc = cur.rdly; gw = -1;
            end else gw--;
          end
        end
      end
    end
  end

  // Write-back monitor: every non-stalled cycle delivers exactly one result.
  wb_t mon_e;
  always @(negedge clk) begin
    if (mon_en && !stall_req_o) begin
      chk("wb_expected", 32'(wb_q.size() != 0), 1);
      if (wb_q.size() != 0) begin
        mon_e = wb_q.pop_front();
        chk("rd_we", rd_we_o, mon_e.rd_we);
        if (mon_e.rd_we) chk("rd_wa", rd_wa_o, mon_e.rd_wa);
        if (mon_e.chk_wd) chk("rd_wd", rd_wd_o, mon_e.rd_wd);
        chk("csr_we", csr_we_o, mon_e.csr_we);
        chk("csr_wa", csr_wa_o, mon_e.csr_wa);
        chk("csr_wd", csr_wd_o, mon_e.csr_wd);
        chk("exception", exception_o, mon_e.exc);
        chk("pc", pc_o, mon_e.pc);
        chk("ins", ins_o, mon_e.ins);
      end
    end
  end

  task automatic bubble();
    flush_i = 0; rd_we_i = 0; rd_wa_i = 0; rd_wd_i = 0; uop_i = 8'h00;
    mem_a_i = 0; mem_wd_i = 0; csr_we_i = 0; csr_wa_i = 0; csr_wd_i = 0;
    exception_i = 0; pc_i = 0; ins_i = NOP;
  endtask

  initial begin
    logic [7:0] u;
    bubble();
    // Reset with a memory uop presented: no request may leave the unit.
    rst_i = 1'b1; uop_i = LW; mem_a_i = 32'h100;
    @(negedge clk);
    chk("rst_req", dbus.req, 0);
    chk("rst_stall", stall_req_o, 0);
    @(posedge clk); #1;
    rst_i = 1'b0; bubble();
    @(negedge clk);
    chk("idle_req", dbus.req, 0);
    chk("idle_stall", stall_req_o, 0);
    chk("idle_rd_we", rd_we_o, 0);
    chk("idle_exc", exception_o, 0);
    chk("idle_pc", pc_o, 0);
    chk("idle_ins", ins_o, NOP);
    // Ungranted store, then reset mid-request: request must drop at once.
    @(posedge clk); #1;
    uop_i = SW; mem_a_i = 32'h304; mem_wd_i = 32'h1234_5678;
    @(negedge clk);
    chk("issue_req", dbus.req, 1);
    chk("issue_addr", dbus.addr, 32'h304);
    @(posedge clk); #1;
    @(negedge clk);
    chk("held_req", dbus.req, 1);
    chk("held_wdata", dbus.wdata, 32'h1234_5678);
    chk("held_stall", stall_req_o, 1);
    @(posedge clk); #1;
    rst_i = 1'b1;
    @(negedge clk);
    chk("midrst_req", dbus.req, 0);
    @(posedge clk); #1;
    rst_i = 1'b0; bubble();
    @(negedge clk);
    chk("postrst_req", dbus.req, 0);
    chk("postrst_stall", stall_req_o, 0);
    @(posedge clk); #1;
    bus_en = 1; mon_en = 1;
    // Directed cases from the feature list.
    issue(LW,  32'h100, 32'h0,         0, 0, 0, 1, 32'hDEAD_BEEF, 0);
    issue(LB,  32'h103, 32'h0,         0, 0, 0, 1, 32'h80FF_1234, 0);
    issue(LBU, 32'h103, 32'h0,         0, 0, 0, 1, 32'h80FF_1234, 0);
    issue(SH,  32'h202, 32'h0000_ABCD, 0, 0, 3, 1, 32'h0,         0);
    issue(LW,  32'h101, 32'h0,         0, 0, 0, 1, 32'h0,         0);
    issue(SW,  32'h400, 32'hCAFE_F00D, 0, 0, 1, 2, 32'h0,         1);
    issue(LW,  32'h500, 32'h0,         0, 2, 0, 3, 32'h5555_AAAA, 0);
    issue(LH,  32'h602, 32'h0,         0, 2, 2, 1, 32'h8001_7FFE, 0);
    issue(LH,  32'h600, 32'h0,         0, 1, 0, 1, 32'h0,         0);
    issue(LW,  32'h700, 32'h0,         32'h4, 0, 0, 1, 32'h0,     0);
    issue(SH,  32'h701, 32'h0,         0, 0, 0, 1, 32'h0,         0);
    issue(8'h01, 32'h0, 32'h0,         0, 0, 0, 1, 32'h0,         0);
    // Random mix.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 4) != 0) u = 8'(LB + $urandom_range(0, 7));
      else begin
        u = 8'($urandom);
        while (u >= LB && u <= SW) u = 8'($urandom);
      end
      issue(u, $urandom, $urandom,
            ($urandom_range(0, 7) == 0) ? (32'd1 << $urandom_range(0, 31)) : 32'd0,
            ($urandom_range(0, 9) == 0) ? 1 : (($urandom_range(0, 9) == 0) ? 2 : 0),
            $urandom_range(0, 3), $urandom_range(1, 3), $urandom,
            1'($urandom_range(0, 7) == 0));
    end
    mon_en = 0;
    chk("wb_left", wb_q.size(), 0);
    chk("bus_left", bus_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_err);
    $fatal(1);
  end
endmodule
